// File: rtl/rob_multi_retire.sv
// rob_multi_retire: reorder buffer with multi-lane in-order retire and exception flush.
// Define ROB_INTERRUPT_EN to add the i_int_req port and per-entry interrupt tags.
module rob_multi_retire #(
  parameter int DEPTH = 64,
  parameter int WB_PORTS = 4,
  parameter int RETIRE_W = 2,
  parameter int PHY_W = 6,
  parameter int EXC_W = 5,
  parameter logic [EXC_W-1:0] INT_CODE = 'h1F,
  parameter int IDW = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_disp_valid,
  output logic                      o_disp_ready,
  input  logic [31:0]               i_disp_pc,
  input  logic [4:0]                i_disp_rd_arch,
  input  logic [PHY_W-1:0]          i_disp_rd_phy,
  input  logic [PHY_W-1:0]          i_disp_rd_origin,
  input  logic [EXC_W-1:0]          i_disp_exc,
  output logic [IDW-1:0]            o_disp_rob_id,
  input  logic [WB_PORTS-1:0]       i_wb_valid,
  input  logic [WB_PORTS*IDW-1:0]   i_wb_rob_id,
  input  logic [WB_PORTS*32-1:0]    i_wb_data,
  input  logic [1:0]                i_exc_valid,
  input  logic [2*IDW-1:0]          i_exc_rob_id,
  input  logic [2*EXC_W-1:0]        i_exc_code,
`ifdef ROB_INTERRUPT_EN
  input  logic                      i_int_req,
`endif
  output logic [RETIRE_W-1:0]       o_ret_valid,
  output logic [RETIRE_W*32-1:0]    o_ret_pc,
  output logic [RETIRE_W*5-1:0]     o_ret_rd_arch,
  output logic [RETIRE_W*PHY_W-1:0] o_ret_rd_phy,
  output logic [RETIRE_W*PHY_W-1:0] o_ret_rd_origin,
  output logic [RETIRE_W*32-1:0]    o_ret_rd_data,
  output logic                      o_flush,
  output logic [EXC_W-1:0]          o_flush_exc,
  output logic [31:0]               o_flush_pc,
  output logic [IDW-1:0]            o_head_id,
  output logic [IDW:0]              o_count
);
  logic [IDW:0]       r_head, r_tail, r_count, w_head_n, w_tail_n, w_nret;
  logic [IDW-1:0]     w_hidx, w_tidx, w_lidx;
  logic [DEPTH-1:0]   r_ready, w_tag;
  logic [EXC_W-1:0]   r_code [DEPTH];
  logic [31:0]        r_pc   [DEPTH];
  logic [31:0]        r_data [DEPTH];
  logic [4:0]         r_arch [DEPTH];
  logic [PHY_W-1:0]   r_phy  [DEPTH];
  logic [PHY_W-1:0]   r_orig [DEPTH];
  logic               w_full, w_flush, w_disp, w_run;

  // An id is live when its distance from head (mod DEPTH) is below the occupancy.
  function automatic logic f_occ(input logic [IDW-1:0] id, input logic [IDW-1:0] hd,
                                 input logic [IDW:0] cnt);
    logic [IDW-1:0] off;
    off = id - hd;
    return {1'b0, off} < cnt;
  endfunction

  assign w_hidx        = r_head[IDW-1:0];
  assign w_tidx        = r_tail[IDW-1:0];
  assign w_full        = (w_hidx == w_tidx) && (r_head[IDW] != r_tail[IDW]);
  assign w_flush       = (r_count != '0) && ((r_code[w_hidx] != '0) || w_tag[w_hidx]);
  assign o_flush       = w_flush;
  assign o_flush_exc   = w_tag[w_hidx] ? INT_CODE : r_code[w_hidx];
  assign o_flush_pc    = r_pc[w_hidx];
  assign o_disp_ready  = !w_full && !w_flush;
  assign w_disp        = i_disp_valid && o_disp_ready;
  assign o_disp_rob_id = w_tidx;
  assign o_head_id     = w_hidx;
  assign o_count       = r_count;
  assign w_head_n      = r_head + w_nret;
  assign w_tail_n      = r_tail + (IDW+1)'(w_disp);

  // Lanes retire as a thermometer: the first unready or excepting entry stops the run.
  always_comb begin
    w_run           = 1'b1;
    w_nret          = '0;
    w_lidx          = w_hidx;
    o_ret_valid     = '0;
    o_ret_pc        = '0;
    o_ret_rd_arch   = '0;
    o_ret_rd_phy    = '0;
    o_ret_rd_origin = '0;
    o_ret_rd_data   = '0;
    for (int k = 0; k < RETIRE_W; k++) begin
      w_lidx = w_hidx + IDW'(k);
      w_run  = w_run && (k < int'(r_count)) && r_ready[w_lidx] &&
               (r_code[w_lidx] == '0) && !w_tag[w_lidx];
      o_ret_valid[k]                  = w_run;
      w_nret                          = w_nret + (IDW+1)'(w_run);
      o_ret_pc[k*32 +: 32]            = r_pc[w_lidx];
      o_ret_rd_arch[k*5 +: 5]         = r_arch[w_lidx];
      o_ret_rd_phy[k*PHY_W +: PHY_W]  = r_phy[w_lidx];
      o_ret_rd_origin[k*PHY_W +: PHY_W] = r_orig[w_lidx];
      o_ret_rd_data[k*32 +: 32]       = r_data[w_lidx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_count <= w_tail_n - w_head_n;
    end
  end

  // Later ports overwrite earlier ones, so the highest-numbered port wins on equal ids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= '0;
      for (int i = 0; i < DEPTH; i++) r_code[i] <= '0;
    end else if (!w_flush) begin
      if (w_disp) begin
        r_ready[w_tidx] <= 1'b0;
        r_code[w_tidx]  <= i_disp_exc;
      end
      for (int p = 0; p < WB_PORTS; p++)
        if (i_wb_valid[p] && f_occ(i_wb_rob_id[p*IDW +: IDW], w_hidx, r_count))
          r_ready[i_wb_rob_id[p*IDW +: IDW]] <= 1'b1;
      for (int i = 0; i < 2; i++)
        if (i_exc_valid[i] && f_occ(i_exc_rob_id[i*IDW +: IDW], w_hidx, r_count))
          r_code[i_exc_rob_id[i*IDW +: IDW]] <= i_exc_code[i*EXC_W +: EXC_W];
    end
  end

  always_ff @(posedge clk) begin
    if (w_disp) begin
      r_pc[w_tidx]   <= i_disp_pc;
      r_arch[w_tidx] <= i_disp_rd_arch;
      r_phy[w_tidx]  <= i_disp_rd_phy;
      r_orig[w_tidx] <= i_disp_rd_origin;
    end
    for (int p = 0; p < WB_PORTS; p++)
      if (!w_flush && i_wb_valid[p] && f_occ(i_wb_rob_id[p*IDW +: IDW], w_hidx, r_count))
        r_data[i_wb_rob_id[p*IDW +: IDW]] <= i_wb_data[p*32 +: 32];
  end

`ifdef ROB_INTERRUPT_EN
  logic [DEPTH-1:0] r_tag;
  logic             r_int_pend;
  assign w_tag = r_tag;
  // A request seen in the same cycle as a dispatch tags that dispatch directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag      <= '0;
      r_int_pend <= 1'b0;
    end else if (w_disp) begin
      r_tag[w_tidx] <= r_int_pend || i_int_req;
      r_int_pend    <= 1'b0;
    end else if (i_int_req) begin
      r_int_pend <= 1'b1;
    end
  end
`else
  assign w_tag = '0;
`endif
endmodule

// File: tb/tb_rob_multi_retire.sv
// tb_rob_multi_retire: directed table, corner sequences and random traffic against a queue model.
module tb_rob_multi_retire;
  localparam int D = 8, WB = 4, RW = 2, PW = 6, EW = 5, IW = 3;
`ifdef ROB_INTERRUPT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic dv, dr, fl, int_req;
  logic [31:0] dpc, fpc;
  logic [4:0] darch;
  logic [PW-1:0] dphy, dorig;
  logic [EW-1:0] dexc, fexc;
  logic [IW-1:0] drid, hid;
  logic [IW:0] cnt;
  logic [WB-1:0] wbv;
  logic [WB*IW-1:0] wbid;
  logic [WB*32-1:0] wbdat;
  logic [1:0] ev;
  logic [2*IW-1:0] eid;
  logic [2*EW-1:0] ecode;
  logic [RW-1:0] rv;
  logic [RW*32-1:0] rpc, rdata;
  logic [RW*5-1:0] rarch;
  logic [RW*PW-1:0] rphy, rorig;

  rob_multi_retire #(.DEPTH(D), .WB_PORTS(WB), .RETIRE_W(RW), .PHY_W(PW), .EXC_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_disp_valid(dv), .o_disp_ready(dr), .i_disp_pc(dpc), .i_disp_rd_arch(darch),
    .i_disp_rd_phy(dphy), .i_disp_rd_origin(dorig), .i_disp_exc(dexc), .o_disp_rob_id(drid),
    .i_wb_valid(wbv), .i_wb_rob_id(wbid), .i_wb_data(wbdat),
    .i_exc_valid(ev), .i_exc_rob_id(eid), .i_exc_code(ecode),
`ifdef ROB_INTERRUPT_EN
    .i_int_req(int_req),
`endif
    .o_ret_valid(rv), .o_ret_pc(rpc), .o_ret_rd_arch(rarch), .o_ret_rd_phy(rphy),
    .o_ret_rd_origin(rorig), .o_ret_rd_data(rdata),
    .o_flush(fl), .o_flush_exc(fexc), .o_flush_pc(fpc), .o_head_id(hid), .o_count(cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int m_head, m_count;
  bit m_pend;
  bit m_ready [D];
  bit m_tag [D];
  logic [EW-1:0] m_code [D];
  logic [31:0] m_pc [D];
  logic [31:0] m_data [D];
  logic [4:0] m_arch [D];
  logic [PW-1:0] m_phy [D];
  logic [PW-1:0] m_orig [D];

  typedef struct {
    logic dv; logic [EW-1:0] dexc; logic [WB-1:0] wbv; logic [WB*IW-1:0] wbid;
    logic [1:0] ev; logic [2*IW-1:0] eid; logic [2*EW-1:0] ecode;
    logic [RW-1:0] x_rv; logic x_fl; logic [EW-1:0] x_fexc; logic [IW:0] x_cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(int dv_, int dexc_, int wbv_, int wbid_, int ev_, int eid_,
                              int ecode_, int rv_, int fl_, int fexc_, int cnt_);
    vec_t v;
    v.dv = 1'(dv_); v.dexc = EW'(dexc_); v.wbv = WB'(wbv_); v.wbid = (WB*IW)'(wbid_);
    v.ev = 2'(ev_); v.eid = (2*IW)'(eid_); v.ecode = (2*EW)'(ecode_);
    v.x_rv = RW'(rv_); v.x_fl = 1'(fl_); v.x_fexc = EW'(fexc_); v.x_cnt = (IW+1)'(cnt_);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_occ(int id);
    return ((id - m_head + D) % D) < m_count;
  endfunction

  function automatic bit m_flush();
    return m_count > 0 && (m_code[m_head] != 0 || m_tag[m_head]);
  endfunction

  function automatic int m_nret();
    int n = 0;
    for (int k = 0; k < RW; k++) begin
      int idx = (m_head + k) % D;
      if (n == k && k < m_count && m_ready[idx] && m_code[idx] == 0 && !m_tag[idx]) n++;
    end
    return n;
  endfunction

  task automatic mreset();
    m_head = 0; m_count = 0; m_pend = 0;
    for (int i = 0; i < D; i++) begin
      m_ready[i] = 0; m_tag[i] = 0; m_code[i] = 0; m_pc[i] = 0; m_data[i] = 0;
      m_arch[i] = 0; m_phy[i] = 0; m_orig[i] = 0;
    end
  endtask

  task automatic mcheck();
    int n = m_nret();
    bit f = m_flush();
    chk("disp_ready", 32'(dr), 32'(m_count < D && !f));
    chk("count", 32'(cnt), m_count);
    chk("head_id", 32'(hid), m_head);
    chk("disp_rob_id", 32'(drid), (m_head + m_count) % D);
    chk("ret_valid", 32'(rv), (1 << n) - 1);
    chk("flush", 32'(fl), 32'(f));
    if (f) begin
      chk("flush_exc", 32'(fexc), 32'(m_tag[m_head] ? 5'h1F : m_code[m_head]));
      chk("flush_pc", fpc, m_pc[m_head]);
    end
    for (int k = 0; k < n; k++) begin
      int idx = (m_head + k) % D;
      chk("ret_pc", rpc[k*32 +: 32], m_pc[idx]);
      chk("ret_data", rdata[k*32 +: 32], m_data[idx]);
      chk("ret_arch", 32'(rarch[k*5 +: 5]), 32'(m_arch[idx]));
      chk("ret_phy", 32'(rphy[k*PW +: PW]), 32'(m_phy[idx]));
      chk("ret_origin", 32'(rorig[k*PW +: PW]), 32'(m_orig[idx]));
    end
  endtask

  task automatic mupdate();
    int n = m_nret();
    bit f = m_flush();
    bit acc = dv && m_count < D && !f;
    if (f) begin
      m_head = 0; m_count = 0;
    end else begin
      for (int p = 0; p < WB; p++) begin
        int id = int'(wbid[p*IW +: IW]);
        if (wbv[p] && m_occ(id)) begin m_ready[id] = 1; m_data[id] = wbdat[p*32 +: 32]; end
      end
      for (int i = 0; i < 2; i++) begin
        int id = int'(eid[i*IW +: IW]);
        if (ev[i] && m_occ(id)) m_code[id] = ecode[i*EW +: EW];
      end
      if (acc) begin
        int t = (m_head + m_count) % D;
        m_pc[t] = dpc; m_arch[t] = darch; m_phy[t] = dphy; m_orig[t] = dorig;
        m_ready[t] = 0; m_code[t] = dexc; m_tag[t] = INT_EN && (m_pend || int_req);
        m_pend = 0;
      end
      m_head = (m_head + n) % D;
      m_count = m_count + int'(acc) - n;
    end
    if (!acc && INT_EN && int_req) m_pend = 1;
  endtask

  task automatic idle();
    dv = 0; dexc = 0; wbv = 0; ev = 0; int_req = 0;
    dpc = $urandom; darch = 5'($urandom); dphy = PW'($urandom); dorig = PW'($urandom);
    wbid = '0; wbdat = {$urandom, $urandom, $urandom, $urandom}; eid = '0; ecode = '0;
  endtask

  task automatic step();
    mcheck();
    mupdate();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drain(input int n);
    repeat (n) begin @(negedge clk); step(); end
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    mreset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic dset(input logic [31:0] pc, input logic [EW-1:0] exc);
    dv = 1; dpc = pc; dexc = exc;
  endtask

  task automatic wset(input int p, input int id);
    wbv[p] = 1; wbid[p*IW +: IW] = IW'(id); wbdat[p*32 +: 32] = $urandom;
  endtask

  initial begin
    idle();
    do_reset();
    @(negedge clk);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_ready", 32'(dr), 1);
    chk("rst_flush", 32'(fl), 0);
    chk("rst_ret_valid", 32'(rv), 0);
    step();

    // ids 0..3 complete out of order, then a truncated retire and a flush
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 'hF, (2 << 9) | (0 << 6) | (1 << 3) | 3, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 'h3, (5 << 3) | 4, 1, 5, 3, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 3, 0, (7 << 5) | 2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    foreach (tbl[i]) begin
      dv = tbl[i].dv; dpc = 32'h1000 + 32'(i) * 16; dexc = tbl[i].dexc;
      wbv = tbl[i].wbv; wbid = tbl[i].wbid;
      ev = tbl[i].ev; eid = tbl[i].eid; ecode = tbl[i].ecode;
      @(negedge clk);
      chk("t_ret_valid", 32'(rv), 32'(tbl[i].x_rv));
      chk("t_flush", 32'(fl), 32'(tbl[i].x_fl));
      if (tbl[i].x_fl) chk("t_flush_exc", 32'(fexc), 32'(tbl[i].x_fexc));
      chk("t_count", 32'(cnt), 32'(tbl[i].x_cnt));
      step();
    end

    // fill to capacity; the ninth dispatch must be refused
    for (int i = 0; i < D; i++) begin dset(32'h2000 + 32'(i) * 4, 0); @(negedge clk); step(); end
    dset(32'h2fff0000, 0);
    @(negedge clk);
    chk("full_count", 32'(cnt), 8);
    chk("full_ready", 32'(dr), 0);
    step();
    @(negedge clk);
    chk("full_hold", 32'(cnt), 8);
    step();
    for (int p = 0; p < 4; p++) wset(p, p);
    @(negedge clk); step();
    for (int p = 0; p < 4; p++) wset(p, p + 4);
    drain(6);
    @(negedge clk);
    chk("drained", 32'(cnt), 0);
    step();

    // move head to 6, then retire across the 7 -> 0 wrap
    for (int i = 0; i < 6; i++) begin dset(32'h3000 + 32'(i) * 4, 0); @(negedge clk); step(); end
    for (int p = 0; p < 4; p++) wset(p, p);
    @(negedge clk); step();
    wset(0, 4); wset(1, 5);
    drain(5);
    @(negedge clk);
    chk("wrap_head0", 32'(hid), 6);
    step();
    for (int i = 0; i < 3; i++) begin dset(32'h4000 + 32'(i) * 4, 0); @(negedge clk); step(); end
    wset(0, 6); wset(1, 7); wset(2, 0);
    @(negedge clk); step();
    @(negedge clk);
    chk("wrap_rv0", 32'(rv), 3);
    chk("wrap_head1", 32'(hid), 6);
    step();
    @(negedge clk);
    chk("wrap_rv1", 32'(rv), 1);
    chk("wrap_head2", 32'(hid), 0);
    step();
    @(negedge clk);
    chk("wrap_head3", 32'(hid), 1);
    chk("wrap_count", 32'(cnt), 0);
    step();

`ifdef ROB_INTERRUPT_EN
    int_req = 1;
    @(negedge clk); step();
    dset(32'h1c000040, 0);
    @(negedge clk); step();
    @(negedge clk);
    chk("int_flush", 32'(fl), 1);
    chk("int_exc", 32'(fexc), 32'h1F);
    chk("int_pc", fpc, 32'h1c000040);
    step();
`endif

    repeat (800) begin
      dv = ($urandom % 4) != 0;
      dexc = ($urandom % 20 == 0) ? EW'($urandom_range(31, 1)) : '0;
      for (int p = 0; p < WB; p++) begin
        int c = (m_count > 0) ? m_count : 1;
        int id = ($urandom % 8 == 0) ? int'($urandom % 8) : (m_head + int'($urandom_range(c - 1, 0))) % D;
        wbv[p] = 1'($urandom);
        wbid[p*IW +: IW] = IW'(id);
      end
      for (int i = 0; i < 2; i++) begin
        ev[i] = ($urandom % 30) == 0;
        eid[i*IW +: IW] = IW'((m_head + int'($urandom % 3)) % D);
        ecode[i*EW +: EW] = EW'($urandom);
      end
      int_req = INT_EN && ($urandom % 60 == 0);
      @(negedge clk);
      step();
    end

    // asynchronous reset with five entries in flight
    do_reset();
    for (int i = 0; i < 5; i++) begin dset(32'h5000 + 32'(i) * 4, 0); @(negedge clk); step(); end
    @(negedge clk);
    chk("pre_rst_count", 32'(cnt), 5);
    step();
    #2;
    rst_n = 0;
    #1;
    chk("arst_count", 32'(cnt), 0);
    chk("arst_ret_valid", 32'(rv), 0);
    chk("arst_flush", 32'(fl), 0);
    chk("arst_ready", 32'(dr), 1);
    mreset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) wset(p, p);
    @(negedge clk); step();
    @(negedge clk);
    chk("post_rst_rv", 32'(rv), 0);
    chk("post_rst_count", 32'(cnt), 0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
